// File: rtl/guess_entry_pkg.sv
// Shared types and constants for the keypad guess-entry block.
// Key codes here are defaults; the top module can override them per instance.
package guess_entry_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 3;

    localparam logic [DIGIT_W-1:0] KEY_CLEAR_DEF = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_BACK_DEF  = 4'hC;
    localparam logic [DIGIT_W-1:0] KEY_ENTER_DEF = 4'hB;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_SEND  = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    function automatic logic is_digit(input digit_t code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/guess_entry_if.sv
// Keypad-in / guess-out bundle between the keypad decoder, this block and the scorer.
// master: the guess-entry block itself; slave: whoever drives keys and consumes guesses.
interface guess_entry_if;
    import guess_entry_pkg::*;

    digit_t                      key_code;
    logic                        key_valid;
    digit_t                      oNum1;
    digit_t                      oNum2;
    digit_t                      oNum3;
    logic                        oNumRdy;
    logic [NUM_DIGITS*DIGIT_W-1:0] oEntry;
    logic [1:0]                  oCount;
    logic                        oErr;
    logic [7:0]                  oRound;

    modport master (
        input  key_code, key_valid,
        output oNum1, oNum2, oNum3, oNumRdy, oEntry, oCount, oErr, oRound
    );

    modport slave (
        output key_code, key_valid,
        input  oNum1, oNum2, oNum3, oNumRdy, oEntry, oCount, oErr, oRound
    );

endinterface

// File: rtl/guess_entry_err_timer.sv
// Down-counter holding the error display for ERR_CYCLES clocks after a load.
// done is high in the last counted cycle so the owner leaves ERROR on that edge.
module err_timer #(
    parameter int ERR_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam int CNT_W = $clog2(ERR_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ERR_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == ONE);

endmodule

// File: rtl/guess_entry.sv
// Assembles keypad digits into a 3-digit guess and strobes it out on oNumRdy.
// Outputs are registered one edge after the key; keys arriving in SEND or ERROR are dropped.
module guess_entry
    import guess_entry_pkg::*;
#(
    parameter digit_t KEY_CLEAR      = KEY_CLEAR_DEF,
    parameter digit_t KEY_BACK       = KEY_BACK_DEF,
    parameter digit_t KEY_ENTER      = KEY_ENTER_DEF,
    parameter bit     REQUIRE_UNIQUE = 1'b1,
    parameter int     ERR_CYCLES     = 25_000_000
) (
    input  logic          clk,
    input  logic          reset,
    guess_entry_if.master ge
);

    state_e     state_q, state_d;
    digit_t     slot_q [NUM_DIGITS];
    digit_t     slot_d [NUM_DIGITS];
    digit_t     num_q  [NUM_DIGITS];
    digit_t     num_d  [NUM_DIGITS];
    logic [1:0] count_q, count_d;
    logic       rdy_q, rdy_d;
    logic       err_q, err_d;
    logic [7:0] round_q, round_d;

    logic       tmr_load;
    logic       tmr_count;
    logic       tmr_done;
    logic       is_dup;

    err_timer #(
        .ERR_CYCLES (ERR_CYCLES)
    ) u_err_timer (
        .clk   (clk),
        .rst   (reset),
        .load  (tmr_load),
        .count (tmr_count),
        .done  (tmr_done)
    );

    // Only slots below the current count hold real digits; stale zeros must not match.
    always_comb begin
        is_dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((2'(i) < count_q) && (slot_q[i] == ge.key_code)) begin
                is_dup = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        num_d     = num_q;
        count_d   = count_q;
        rdy_d     = 1'b0;
        err_d     = err_q;
        round_d   = round_q;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (ge.key_valid) begin
                    if (is_digit(ge.key_code)) begin
                        if (count_q != 2'd3) begin
                            if (REQUIRE_UNIQUE && is_dup) begin
                                state_d  = ST_ERROR;
                                err_d    = 1'b1;
                                tmr_load = 1'b1;
                            end else begin
                                for (int i = 0; i < NUM_DIGITS; i++) begin
                                    if (2'(i) == count_q) begin
                                        slot_d[i] = ge.key_code;
                                    end
                                end
                                count_d = count_q + 2'd1;
                            end
                        end
                    end else if (ge.key_code == KEY_BACK) begin
                        if (count_q != 2'd0) begin
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (2'(i) == (count_q - 2'd1)) begin
                                    slot_d[i] = '0;
                                end
                            end
                            count_d = count_q - 2'd1;
                        end
                    end else if (ge.key_code == KEY_CLEAR) begin
                        slot_d  = '{default: '0};
                        count_d = 2'd0;
                    end else if (ge.key_code == KEY_ENTER) begin
                        if (count_q == 2'd3) begin
                            // Round counts on the same edge as the strobe so it is valid with oNumRdy.
                            num_d   = slot_q;
                            rdy_d   = 1'b1;
                            state_d = ST_SEND;
                            if (round_q != 8'hFF) begin
                                round_d = round_q + 8'd1;
                            end
                        end else begin
                            state_d  = ST_ERROR;
                            err_d    = 1'b1;
                            tmr_load = 1'b1;
                        end
                    end
                end
            end

            ST_SEND: begin
                slot_d  = '{default: '0};
                count_d = 2'd0;
                state_d = ST_ENTRY;
            end

            ST_ERROR: begin
                tmr_count = 1'b1;
                if (tmr_done) begin
                    slot_d  = '{default: '0};
                    count_d = 2'd0;
                    err_d   = 1'b0;
                    state_d = ST_ENTRY;
                end
            end

            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ENTRY;
            slot_q  <= '{default: '0};
            num_q   <= '{default: '0};
            count_q <= 2'd0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            round_q <= 8'd0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            num_q   <= num_d;
            count_q <= count_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            round_q <= round_d;
        end
    end

    assign ge.oNum1   = num_q[0];
    assign ge.oNum2   = num_q[1];
    assign ge.oNum3   = num_q[2];
    assign ge.oNumRdy = rdy_q;
    assign ge.oEntry  = {slot_q[0], slot_q[1], slot_q[2]};
    assign ge.oCount  = count_q;
    assign ge.oErr    = err_q;
    assign ge.oRound  = round_q;

endmodule

// File: tb/tb_guess_entry.sv
// Scenario bench for guess_entry: scoreboard of expected guesses checked on each oNumRdy.
module tb_guess_entry;

    localparam logic [3:0] K_CLEAR = 4'hA;
    localparam logic [3:0] K_BACK  = 4'hC;
    localparam logic [3:0] K_ENTER = 4'hB;
    localparam int         ERRC    = 8;

    typedef struct packed {
        logic [3:0] n1;
        logic [3:0] n2;
        logic [3:0] n3;
        logic [7:0] round;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic prev_rdy = 1'b0;
    int   exp_round = 0;

    guess_entry_if ge_if();

    guess_entry #(
        .ERR_CYCLES (ERRC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ge    (ge_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (ge_if.oNumRdy === 1'b1) begin
            total++;
            if (prev_rdy === 1'b1) begin
                bad++;
                $display("FAIL rdy_consecutive got=1 exp=0");
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rdy got num=%h%h%h exp=no strobe",
                         ge_if.oNum1, ge_if.oNum2, ge_if.oNum3);
            end else begin
                e = sb.pop_front();
                if ({ge_if.oNum1, ge_if.oNum2, ge_if.oNum3, ge_if.oRound} !== e) begin
                    bad++;
                    $display("FAIL guess_out got=%h%h%h r%0d exp=%h%h%h r%0d",
                             ge_if.oNum1, ge_if.oNum2, ge_if.oNum3, ge_if.oRound,
                             e.n1, e.n2, e.n3, e.round);
                end
            end
        end
        prev_rdy = ge_if.oNumRdy;
    endtask

    task automatic press(input logic [3:0] k);
        ge_if.key_code  = k;
        ge_if.key_valid = 1'b1;
        tick();
        ge_if.key_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        exp_round = (exp_round < 255) ? exp_round + 1 : 255;
        sb.push_back({a, b, c, 8'(exp_round)});
    endtask

    task automatic submit(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        press(a);
        press(b);
        press(c);
        push_exp(a, b, c);
        press(K_ENTER);
        tick();
    endtask

    task automatic wait_err_clear(input string name);
        int guard = 0;
        while (ge_if.oErr === 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 100) begin
            bad++;
            $display("FAIL %s_timeout got=oErr stuck exp=clear within 100 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ge_if.key_code  = 4'h0;
        ge_if.key_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({ge_if.oNum1, ge_if.oNum2, ge_if.oNum3, ge_if.oNumRdy, ge_if.oEntry,
             ge_if.oCount, ge_if.oErr, ge_if.oRound} !== 36'd0) begin
            bad++;
            $display("FAIL reset_state got=%h%h%h rdy=%b e=%h c=%0d err=%b r=%0d exp=all zero",
                     ge_if.oNum1, ge_if.oNum2, ge_if.oNum3, ge_if.oNumRdy, ge_if.oEntry,
                     ge_if.oCount, ge_if.oErr, ge_if.oRound);
        end
        reset = 1'b0;
        sb.delete();
        exp_round = 0;
        prev_rdy = 1'b0;
    endtask

    task automatic test_basic();
        press(4'd1);
        press(4'd2);
        press(4'd3);
        total++;
        if (ge_if.oCount !== 2'd3 || ge_if.oEntry !== 12'h123) begin
            bad++;
            $display("FAIL basic_entry got=c%0d e%h exp=c3 e123", ge_if.oCount, ge_if.oEntry);
        end
        push_exp(4'd1, 4'd2, 4'd3);
        press(K_ENTER);
        total++;
        if (ge_if.oNumRdy !== 1'b1 || ge_if.oRound !== 8'd1) begin
            bad++;
            $display("FAIL basic_strobe got=rdy%b r%0d exp=rdy1 r1", ge_if.oNumRdy, ge_if.oRound);
        end
        tick();
        total++;
        if (ge_if.oNumRdy !== 1'b0 || ge_if.oCount !== 2'd0 || ge_if.oEntry !== 12'h000) begin
            bad++;
            $display("FAIL basic_after got=rdy%b c%0d e%h exp=rdy0 c0 e000",
                     ge_if.oNumRdy, ge_if.oCount, ge_if.oEntry);
        end
    endtask

    task automatic test_dup_error();
        int n = 1;
        int guard = 0;
        press(4'd4);
        press(4'd4);
        total++;
        if (ge_if.oErr !== 1'b1 || ge_if.oCount !== 2'd1 || ge_if.oEntry !== 12'h400) begin
            bad++;
            $display("FAIL dup_enter_err got=err%b c%0d e%h exp=err1 c1 e400",
                     ge_if.oErr, ge_if.oCount, ge_if.oEntry);
        end
        // Hammer keys for the whole error window; none may land.
        while (ge_if.oErr === 1'b1 && guard < 100) begin
            ge_if.key_code  = 4'(guard);
            ge_if.key_valid = 1'b1;
            tick();
            guard++;
            if (ge_if.oErr === 1'b1) begin
                n++;
                total++;
                if (ge_if.oCount !== 2'd1 || ge_if.oEntry !== 12'h400) begin
                    bad++;
                    $display("FAIL dup_keys_dropped got=c%0d e%h exp=c1 e400",
                             ge_if.oCount, ge_if.oEntry);
                end
            end
        end
        ge_if.key_valid = 1'b0;
        total++;
        if (n !== ERRC) begin
            bad++;
            $display("FAIL dup_err_len got=%0d exp=%0d", n, ERRC);
        end
        total++;
        if (ge_if.oCount !== 2'd0 || ge_if.oEntry !== 12'h000 ||
            {ge_if.oNum1, ge_if.oNum2, ge_if.oNum3} !== 12'h123) begin
            bad++;
            $display("FAIL dup_after got=c%0d e%h num=%h%h%h exp=c0 e000 num=123",
                     ge_if.oCount, ge_if.oEntry, ge_if.oNum1, ge_if.oNum2, ge_if.oNum3);
        end
    endtask

    task automatic test_back_error();
        press(4'd5);
        press(4'd6);
        press(K_BACK);
        total++;
        if (ge_if.oCount !== 2'd1 || ge_if.oEntry !== 12'h500) begin
            bad++;
            $display("FAIL back_slot got=c%0d e%h exp=c1 e500", ge_if.oCount, ge_if.oEntry);
        end
        press(4'd7);
        total++;
        if (ge_if.oCount !== 2'd2 || ge_if.oEntry !== 12'h570) begin
            bad++;
            $display("FAIL back_retype got=c%0d e%h exp=c2 e570", ge_if.oCount, ge_if.oEntry);
        end
        press(K_ENTER);
        total++;
        if (ge_if.oErr !== 1'b1 || ge_if.oNumRdy !== 1'b0) begin
            bad++;
            $display("FAIL short_enter got=err%b rdy%b exp=err1 rdy0", ge_if.oErr, ge_if.oNumRdy);
        end
        wait_err_clear("short_enter");
        submit(4'd5, 4'd7, 4'd8);
    endtask

    task automatic test_clear();
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd9);
        total++;
        if (ge_if.oCount !== 2'd3 || ge_if.oEntry !== 12'h123) begin
            bad++;
            $display("FAIL full_ignore got=c%0d e%h exp=c3 e123", ge_if.oCount, ge_if.oEntry);
        end
        press(K_CLEAR);
        total++;
        if (ge_if.oCount !== 2'd0 || ge_if.oEntry !== 12'h000) begin
            bad++;
            $display("FAIL clear got=c%0d e%h exp=c0 e000", ge_if.oCount, ge_if.oEntry);
        end
        press(4'd9);
        press(4'd8);
        press(4'd7);
        total++;
        if ({ge_if.oNum1, ge_if.oNum2, ge_if.oNum3} !== 12'h578) begin
            bad++;
            $display("FAIL num_held got=%h%h%h exp=578", ge_if.oNum1, ge_if.oNum2, ge_if.oNum3);
        end
        push_exp(4'd9, 4'd8, 4'd7);
        press(K_ENTER);
        tick();
    endtask

    task automatic test_send_drop();
        press(4'd2);
        press(4'd4);
        press(4'd6);
        push_exp(4'd2, 4'd4, 4'd6);
        press(K_ENTER);
        press(4'd1);
        total++;
        if (ge_if.oCount !== 2'd0 || ge_if.oEntry !== 12'h000) begin
            bad++;
            $display("FAIL send_drop got=c%0d e%h exp=c0 e000", ge_if.oCount, ge_if.oEntry);
        end
        press(4'd3);
        total++;
        if (ge_if.oCount !== 2'd1 || ge_if.oEntry !== 12'h300) begin
            bad++;
            $display("FAIL after_send got=c%0d e%h exp=c1 e300", ge_if.oCount, ge_if.oEntry);
        end
        press(K_CLEAR);
    endtask

    task automatic test_async_reset();
        press(4'd1);
        press(4'd2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({ge_if.oNum1, ge_if.oNum2, ge_if.oNum3, ge_if.oNumRdy, ge_if.oEntry,
             ge_if.oCount, ge_if.oErr, ge_if.oRound} !== 36'd0) begin
            bad++;
            $display("FAIL reset_mid_entry got=e%h c%0d r%0d exp=all zero",
                     ge_if.oEntry, ge_if.oCount, ge_if.oRound);
        end
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_round = 0;
        prev_rdy = 1'b0;
        press(K_ENTER);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (ge_if.oErr !== 1'b0 || ge_if.oCount !== 2'd0 || ge_if.oRound !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid_error got=err%b c%0d r%0d exp=err0 c0 r0",
                     ge_if.oErr, ge_if.oCount, ge_if.oRound);
        end
        @(negedge clk);
        reset = 1'b0;
        submit(4'd3, 4'd1, 4'd4);
    endtask

    task automatic test_round_sat();
        for (int i = 0; i < 260; i++) begin
            submit(4'(i % 10), 4'((i + 3) % 10), 4'((i + 6) % 10));
        end
        total++;
        if (ge_if.oRound !== 8'd255) begin
            bad++;
            $display("FAIL round_sat got=%0d exp=255", ge_if.oRound);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dup_error();
        test_back_error();
        test_clear();
        test_send_drop();
        test_async_reset();
        test_round_sat();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_strobes got=%0d pending exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
